// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit
// Description : Byte-addressed little-endian data memory with one-cycle,
//               back-pressurable load/store responses and fault counting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [CNT_WIDTH-1:0]  fault_cnt
);

    localparam int                    c_IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("data_mem_unit: DATA_WIDTH must be 32");
        end
        if ((MEM_DEPTH < 4) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("data_mem_unit: MEM_DEPTH must be a power of two >= 4");
        end
    endgenerate

    logic [7:0]            mem_q [MEM_DEPTH];
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;
    logic [CNT_WIDTH-1:0]  fault_cnt_q;

    logic [DATA_WIDTH-1:0] resp_rdata_d;
    logic                  w_accept;
    logic                  w_fault;
    logic                  w_sign;
    logic [2:0]            w_nbytes;
    logic [ADDR_WIDTH:0]   w_end;
    logic [c_IDX_W-1:0]    w_idx;
    logic [7:0]            w_b [4];

    assign req_ready = !resp_valid_q || resp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[c_IDX_W-1:0];

    always_comb begin
        w_nbytes = 3'd4;
        case (req_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    // Range check done one bit wider than the address so a top-of-space
    // address cannot wrap back into the array.
    assign w_end   = {1'b0, req_addr} + (ADDR_WIDTH+1)'(w_nbytes);
    assign w_fault = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  || (w_end > c_DEPTH);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_b[k] = mem_q[w_idx + c_IDX_W'(k)];
        end
    end

    always_comb begin
        w_sign       = 1'b0;
        resp_rdata_d = '0;
        case (req_size)
            2'b00: begin
                w_sign       = !req_unsigned && w_b[0][7];
                resp_rdata_d = {{24{w_sign}}, w_b[0]};
            end
            2'b01: begin
                w_sign       = !req_unsigned && w_b[1][7];
                resp_rdata_d = {{16{w_sign}}, w_b[1], w_b[0]};
            end
            2'b10: resp_rdata_d = {w_b[3], w_b[2], w_b[1], w_b[0]};
            default: resp_rdata_d = '0;
        endcase
        if (req_we || w_fault) begin
            resp_rdata_d = '0;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && req_we && !w_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(w_nbytes)) begin
                    mem_q[w_idx + c_IDX_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            fault_cnt_q  <= '0;
        end else begin
            if (w_accept) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= resp_rdata_d;
                resp_err_q   <= w_fault;
                if (w_fault && (fault_cnt_q != {CNT_WIDTH{1'b1}})) begin
                    fault_cnt_q <= fault_cnt_q + CNT_WIDTH'(1);
                end
            end else if (resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign fault_cnt  = fault_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Scoreboard bench for data_mem_unit (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [CW-1:0] fault_cnt;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [32:0] exp_q [$];

    data_mem_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: a response is consumed on the posedge following this negedge.
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && resp_ready) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, none expected", resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                pops++;
                if ({resp_err, resp_rdata} !== e) begin
                    errors++;
                    $display("FAIL resp#%0d: got err=%b rdata=%h, want err=%b rdata=%h",
                             pops, resp_err, resp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        int t = 0;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: req_ready=%b, want 1", req_ready);
        end else begin
            exp_q.push_back({exp_err, exp_rd});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); t++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err",   32'(resp_err), 32'd0);
        check("rst_cnt",   32'(fault_cnt), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Sizes and extension
        issue(1, 2'b10, 0, 32'h10, 32'h8000_00F0, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFF_FFF0, 0);
        issue(0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_00F0, 0);
        issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_8000, 0);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_8000, 0);
        // Partial store
        issue(1, 2'b10, 0, 32'h20, 32'h1122_3344, 32'h0, 0);
        issue(1, 2'b00, 0, 32'h21, 32'hFFFF_FFAA, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h1122_AA44, 0);
        // Faults
        issue(1, 2'b10, 0, 32'h30, 32'hCAFE_F00D, 32'h0, 0);
        issue(1, 2'b01, 0, 32'h31, 32'h0000_BEEF, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h32, 32'h0, 32'h0, 1);
        issue(1, 2'b11, 0, 32'h40, 32'h1234_5678, 32'h0, 1);
        issue(0, 2'b10, 0, DEPTH - 2, 32'h0, 32'h0, 1);
        drain();
        check("fault_cnt_4", 32'(fault_cnt), 32'd4);
        issue(0, 2'b10, 0, 32'h30, 32'h0, 32'hCAFE_F00D, 0);
        issue(1, 2'b10, 0, DEPTH - 4, 32'h0BAD_C0DE, 32'h0, 0);
        issue(0, 2'b10, 0, DEPTH - 4, 32'h0, 32'h0BAD_C0DE, 0);
        issue(0, 2'b00, 1, DEPTH - 1, 32'h0, 32'h0000_000B, 0);
        issue(0, 2'b10, 0, DEPTH, 32'h0, 32'h0, 1);
        issue(0, 2'b10, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1);
        drain();
        check("fault_cnt_6", 32'(fault_cnt), 32'd6);
        issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
        issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
        issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
        drain();
        check("fault_cnt_sat", 32'(fault_cnt), 32'd7);

        // Back-pressure
        resp_ready = 1'b0;
        issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h1122_AA44, 0);
        req_we = 0; req_size = 2'b00; req_unsigned = 1; req_addr = 32'h10; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, 32'h1122_AA44);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        issue(0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_00F0, 0);
        drain();

        // Reset mid-operation
        issue(1, 2'b10, 0, 32'h50, 32'h5555_AAAA, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h50, 32'h0, 32'h5555_AAAA, 0);
        rst = 1'b1;
        req_we = 1; req_size = 2'b10; req_addr = 32'h50; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_cnt",   32'(fault_cnt), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        issue(0, 2'b10, 0, 32'h50, 32'h0, 32'h5555_AAAA, 0);
        drain();

        // Back-to-back store then load of the same byte
        begin
            int p0;
            p0 = pops;
            issue(1, 2'b00, 0, 32'h60, 32'h0000_007F, 32'h0, 0);
            issue(0, 2'b00, 0, 32'h60, 32'h0, 32'h0000_007F, 0);
            check("b2b_pops",  32'(pops - p0), 32'd1);
            check("b2b_valid", 32'(resp_valid), 32'd1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
